// File: rtl/jogo_pkg.sv
// Shared definitions for the ultimate tic-tac-toe board updater: cell codes,
// controller states and the table of the eight winning lines of a 3x3 board.
package jogo_pkg;

  localparam int unsigned N_CELULAS = 9;

  localparam logic [1:0] VAZIO  = 2'b00;
  localparam logic [1:0] X      = 2'b01;
  localparam logic [1:0] O      = 2'b10;
  localparam logic [1:0] EMPATE = 2'b11;

  typedef enum logic [3:0] {
    StLimpa,
    StIdle,
    StCheca,
    StErro,
    StGrava,
    StVarreMicro,
    StAtualiza,
    StVarreMacro,
    StFeito
  } estado_t;

  // Lines 0..2 rows, 3..5 columns, 6..7 diagonals; three cell indices each.
  localparam logic [0:7][0:2][3:0] LINHAS = {
    4'd0, 4'd1, 4'd2,
    4'd3, 4'd4, 4'd5,
    4'd6, 4'd7, 4'd8,
    4'd0, 4'd3, 4'd6,
    4'd1, 4'd4, 4'd7,
    4'd2, 4'd5, 4'd8,
    4'd0, 4'd4, 4'd8,
    4'd2, 4'd4, 4'd6
  };

  function automatic logic [1:0] codigo_jogador(input logic jogador);
    return jogador ? O : X;
  endfunction

endpackage

// File: rtl/verifica_linha.sv
// Combinational check: are all three cells of one line of a 3x3 board equal
// to the given player code.
module verifica_linha
  import jogo_pkg::*;
(
  input  logic [N_CELULAS-1:0][1:0] i_tabuleiro,
  input  logic [2:0]                i_linha,
  input  logic [1:0]                i_codigo,
  output logic                      o_acerto
);

  always_comb begin
    o_acerto = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (i_tabuleiro[LINHAS[i_linha][k]] != i_codigo) begin
        o_acerto = 1'b0;
      end
    end
  end

endmodule

// File: rtl/atualiza_tabuleiro.sv
// Commits one move to the 81-cell ultimate tic-tac-toe board, resolves the
// micro board and the game, and mirrors closed micro boards to an external RAM.
module atualiza_tabuleiro
  import jogo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       inicia,
  input  logic [3:0] macro_idx,
  input  logic [3:0] micro_idx,
  input  logic       jogador,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic       micro_vencida,
  output logic       fim_jogo,
  output logic [1:0] vencedor,
  output logic       macro_we,
  output logic [3:0] macro_addr,
  output logic [1:0] macro_data
);

  estado_t                   r_estado;
  logic [3:0]                r_cnt;
  logic [3:0]                r_macro;
  logic [3:0]                r_micro;
  logic [1:0]                r_codigo;
  logic                      r_acerto;
  logic [1:0]                r_cel [81];
  logic [N_CELULAS-1:0][1:0] r_sombra;
  logic                      r_micro_vencida;
  logic                      r_fim;
  logic [1:0]                r_vencedor;

  logic [6:0]                w_base;
  logic [6:0]                w_idx;
  logic [1:0]                w_cel_alvo;
  logic [1:0]                w_sombra_alvo;
  logic [N_CELULAS-1:0][1:0] w_micro_tab;
  logic                      w_micro_cheio;
  logic                      w_macro_cheio;
  logic                      w_acerto_micro;
  logic                      w_acerto_macro;
  logic                      w_invalido;
  logic [1:0]                w_novo;

  // Out-of-range indices wrap here, but CHECA rejects them before any write.
  assign w_base = 7'(r_macro) * 7'd9;
  assign w_idx  = w_base + 7'(r_micro);

  always_comb begin
    w_cel_alvo = VAZIO;
    if (w_idx < 7'd81) begin
      w_cel_alvo = r_cel[w_idx];
    end
  end

  assign w_sombra_alvo = (r_macro < 4'd9) ? r_sombra[r_macro] : VAZIO;

  always_comb begin
    w_micro_cheio = 1'b1;
    w_macro_cheio = 1'b1;
    for (int i = 0; i < N_CELULAS; i++) begin
      w_micro_tab[i] = VAZIO;
      if (w_base + 7'(i) < 7'd81) begin
        w_micro_tab[i] = r_cel[w_base + 7'(i)];
      end
      if (w_micro_tab[i] == VAZIO) w_micro_cheio = 1'b0;
      if (r_sombra[i] == VAZIO)    w_macro_cheio = 1'b0;
    end
  end

  assign w_invalido = (r_macro > 4'd8) || (r_micro > 4'd8) || (w_cel_alvo != VAZIO) ||
                      (w_sombra_alvo != VAZIO) || r_fim;

  assign w_novo = r_acerto ? r_codigo : (w_micro_cheio ? EMPATE : VAZIO);

  verifica_linha u_linha_micro (
    .i_tabuleiro (w_micro_tab),
    .i_linha     (r_cnt[2:0]),
    .i_codigo    (r_codigo),
    .o_acerto    (w_acerto_micro)
  );

  // Player codes are never 11, so drawn macro cells can't complete a line.
  verifica_linha u_linha_macro (
    .i_tabuleiro (r_sombra),
    .i_linha     (r_cnt[2:0]),
    .i_codigo    (r_codigo),
    .o_acerto    (w_acerto_macro)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado        <= StLimpa;
      r_cnt           <= '0;
      r_macro         <= '0;
      r_micro         <= '0;
      r_codigo        <= X;
      r_acerto        <= 1'b0;
      r_sombra        <= '0;
      r_micro_vencida <= 1'b0;
      r_fim           <= 1'b0;
      r_vencedor      <= VAZIO;
      for (int i = 0; i < 81; i++) begin
        r_cel[i] <= VAZIO;
      end
    end else begin
      unique case (r_estado)
        StLimpa: begin
          if (r_cnt == 4'(N_CELULAS - 1)) begin
            r_cnt    <= '0;
            r_estado <= StIdle;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StIdle: begin
          if (inicia) begin
            r_macro         <= macro_idx;
            r_micro         <= micro_idx;
            r_codigo        <= codigo_jogador(jogador);
            r_micro_vencida <= 1'b0;
            r_estado        <= StCheca;
          end
        end
        StCheca: r_estado <= w_invalido ? StErro : StGrava;
        StErro:  r_estado <= StIdle;
        StGrava: begin
          r_cel[w_idx] <= r_codigo;
          r_cnt        <= '0;
          r_acerto     <= 1'b0;
          r_estado     <= StVarreMicro;
        end
        StVarreMicro: begin
          r_acerto <= r_acerto | w_acerto_micro;
          r_cnt    <= r_cnt + 4'd1;
          if (r_cnt == 4'd7) r_estado <= StAtualiza;
        end
        StAtualiza: begin
          if (w_novo != VAZIO) begin
            r_sombra[r_macro] <= w_novo;
            r_micro_vencida   <= 1'b1;
          end
          r_cnt    <= '0;
          r_acerto <= 1'b0;
          r_estado <= StVarreMacro;
        end
        StVarreMacro: begin
          r_acerto <= r_acerto | w_acerto_macro;
          r_cnt    <= r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            if (r_acerto || w_acerto_macro) begin
              r_fim      <= 1'b1;
              r_vencedor <= r_codigo;
            end else if (w_macro_cheio) begin
              r_fim      <= 1'b1;
              r_vencedor <= EMPATE;
            end
            r_estado <= StFeito;
          end
        end
        StFeito: r_estado <= StIdle;
        default: r_estado <= StLimpa;
      endcase
    end
  end

  assign ocupado       = (r_estado != StIdle);
  assign pronto        = (r_estado == StErro) || (r_estado == StFeito);
  assign erro          = (r_estado == StErro);
  assign micro_vencida = r_micro_vencida;
  assign fim_jogo      = r_fim;
  assign vencedor      = r_vencedor;

  always_comb begin
    macro_we   = 1'b0;
    macro_addr = r_macro;
    macro_data = VAZIO;
    if (r_estado == StLimpa) begin
      macro_we   = 1'b1;
      macro_addr = r_cnt;
    end else if (r_estado == StAtualiza) begin
      macro_we   = (w_novo != VAZIO);
      macro_data = w_novo;
    end
  end

endmodule

// File: tb/tb_atualiza_tabuleiro.sv
// Self-checking bench for atualiza_tabuleiro: a reference board model pushes
// expected move results to a scoreboard that is popped when pronto arrives.
module tb_atualiza_tabuleiro;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       inicia = 1'b0;
  logic [3:0] macro_idx = '0;
  logic [3:0] micro_idx = '0;
  logic       jogador = 1'b0;
  logic       ocupado, pronto, erro, micro_vencida, fim_jogo, macro_we;
  logic [1:0] vencedor, macro_data;
  logic [3:0] macro_addr;

  always #5 clock = ~clock;

  atualiza_tabuleiro dut (
    .clock         (clock),
    .reset         (reset),
    .inicia        (inicia),
    .macro_idx     (macro_idx),
    .micro_idx     (micro_idx),
    .jogador       (jogador),
    .ocupado       (ocupado),
    .pronto        (pronto),
    .erro          (erro),
    .micro_vencida (micro_vencida),
    .fim_jogo      (fim_jogo),
    .vencedor      (vencedor),
    .macro_we      (macro_we),
    .macro_addr    (macro_addr),
    .macro_data    (macro_data)
  );

  int n_comp = 0;
  int n_falha = 0;

  task automatic verifica(input string tag, input logic [191:0] obs, input logic [191:0] esp);
    n_comp++;
    if (obs !== esp) begin
      n_falha++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, esp);
    end
  endtask

  // Reference model
  logic [1:0] m_cel [81];
  logic [1:0] m_sombra [9];
  logic       m_fim;
  logic [1:0] m_venc;
  int         lin [8][3];

  typedef struct {
    logic       erro;
    int         lat;
    logic       mv;
    int         n_we;
    logic [3:0] addr;
    logic [1:0] dado;
    logic       fim;
    logic [1:0] venc;
  } esp_t;

  esp_t sb[$];

  function automatic logic tem_linha(input logic [8:0][1:0] t, input logic [1:0] c);
    logic r;
    r = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (t[lin[l][0]] == c && t[lin[l][1]] == c && t[lin[l][2]] == c) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic cheio(input logic [8:0][1:0] t);
    logic r;
    r = 1'b1;
    for (int i = 0; i < 9; i++) if (t[i] == 2'b00) r = 1'b0;
    return r;
  endfunction

  task automatic modelo(input int mac, input int mic, input logic jog);
    esp_t            e;
    logic [8:0][1:0] t;
    logic [1:0]      c;
    logic [1:0]      novo;
    logic            ok;
    c = jog ? 2'b10 : 2'b01;
    e.n_we = 0; e.addr = '0; e.dado = '0; e.mv = 1'b0;
    ok = (mac <= 8) && (mic <= 8) && !m_fim;
    if (ok) ok = (m_sombra[mac] == 2'b00) && (m_cel[mac*9+mic] == 2'b00);
    if (!ok) begin
      e.erro = 1'b1;
      e.lat  = 2;
    end else begin
      e.erro = 1'b0;
      e.lat  = 20;
      m_cel[mac*9+mic] = c;
      for (int i = 0; i < 9; i++) t[i] = m_cel[mac*9+i];
      novo = tem_linha(t, c) ? c : (cheio(t) ? 2'b11 : 2'b00);
      if (novo != 2'b00) begin
        m_sombra[mac] = novo;
        e.n_we = 1; e.addr = 4'(mac); e.dado = novo; e.mv = 1'b1;
      end
      for (int i = 0; i < 9; i++) t[i] = m_sombra[i];
      if (tem_linha(t, c)) begin
        m_fim = 1'b1; m_venc = c;
      end else if (cheio(t)) begin
        m_fim = 1'b1; m_venc = 2'b11;
      end
    end
    e.fim = m_fim;
    e.venc = m_venc;
    sb.push_back(e);
  endtask

  task automatic limpa_modelo();
    for (int i = 0; i < 81; i++) m_cel[i] = 2'b00;
    for (int i = 0; i < 9; i++) m_sombra[i] = 2'b00;
    m_fim = 1'b0;
    m_venc = 2'b00;
  endtask

  task automatic aplica_reset();
    reset = 1'b1;
    inicia = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    limpa_modelo();
    for (int i = 0; i < 9; i++) begin
      verifica("limpa_we", macro_we, 1);
      verifica("limpa_addr", macro_addr, i);
      verifica("limpa_data", macro_data, 0);
      verifica("limpa_ocupado", ocupado, 1);
      @(posedge clock); #1;
    end
    verifica("idle_ocupado", ocupado, 0);
    verifica("idle_we", macro_we, 0);
    verifica("reset_pronto_erro", {pronto, erro}, 0);
    verifica("reset_fim_venc", {fim_jogo, vencedor}, 0);
    verifica("reset_micro_vencida", micro_vencida, 0);
  endtask

  // Called at #1 after an edge with the DUT idle.
  task automatic jogar(input int mac, input int mic, input logic jog, input logic extra);
    esp_t       e;
    int         lat;
    int         n_we;
    logic [3:0] we_addr;
    logic [1:0] we_dado;
    logic       achou;
    modelo(mac, mic, jog);
    macro_idx = 4'(mac); micro_idx = 4'(mic); jogador = jog; inicia = 1'b1;
    @(posedge clock); #1;
    inicia = 1'b0;
    lat = 1; n_we = 0; achou = 1'b0; we_addr = '0; we_dado = '0;
    while (!achou && lat < 40) begin
      if (macro_we) begin
        n_we++; we_addr = macro_addr; we_dado = macro_data;
      end
      if (pronto) begin
        achou = 1'b1;
      end else begin
        if (extra && lat == 5) begin
          inicia = 1'b1; macro_idx = 4'd8; micro_idx = 4'd8;
        end
        @(posedge clock); #1;
        inicia = 1'b0;
        lat++;
      end
    end
    if (!achou) begin
      verifica("pronto_timeout", 0, 1);
      void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      verifica("scoreboard_vazio", 0, 1);
    end else begin
      e = sb.pop_front();
      verifica("latencia", lat, e.lat);
      verifica("erro", erro, e.erro);
      verifica("micro_vencida", micro_vencida, e.mv);
      verifica("n_macro_we", n_we, e.n_we);
      if (e.n_we != 0) verifica("macro_we_addr_data", {we_addr, we_dado}, {e.addr, e.dado});
      verifica("fim_vencedor", {fim_jogo, vencedor}, {e.fim, e.venc});
      verifica("ocupado_no_pronto", ocupado, 1);
    end
    @(posedge clock); #1;
    verifica("volta_idle", {ocupado, pronto}, 0);
  endtask

  task automatic compara_memoria(input string tag);
    logic [161:0] obs, esp;
    logic [17:0]  obs_s, esp_s;
    for (int i = 0; i < 81; i++) begin
      obs[2*i +: 2] = dut.r_cel[i];
      esp[2*i +: 2] = m_cel[i];
    end
    for (int i = 0; i < 9; i++) begin
      obs_s[2*i +: 2] = dut.r_sombra[i];
      esp_s[2*i +: 2] = m_sombra[i];
    end
    verifica({tag, "_celulas"}, obs, esp);
    verifica({tag, "_sombra"}, obs_s, esp_s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        lin[r][k]   = 3*r + k;
        lin[3+r][k] = r + 3*k;
      end
    end
    lin[6][0] = 0; lin[6][1] = 4; lin[6][2] = 8;
    lin[7][0] = 2; lin[7][1] = 4; lin[7][2] = 6;

    aplica_reset();

    // Simple move, then X closes macro 2 with micros 0,4,8
    jogar(4, 0, 0, 0);
    jogar(2, 0, 0, 0);
    jogar(5, 0, 1, 0);
    jogar(2, 4, 0, 0);
    jogar(5, 1, 1, 0);
    jogar(2, 8, 0, 0);

    // Rejections: occupied cell, micro 9, won macro, macro 9
    jogar(4, 0, 1, 0);
    jogar(3, 9, 1, 0);
    jogar(2, 1, 1, 0);
    jogar(9, 0, 0, 0);
    compara_memoria("rejeicao");

    // X wins macros 0 and 1 -> top row of the macro board
    jogar(0, 0, 0, 0);
    jogar(6, 0, 1, 0);
    jogar(0, 4, 0, 0);
    jogar(6, 1, 1, 0);
    jogar(0, 8, 0, 0);
    jogar(7, 0, 1, 0);
    jogar(1, 0, 0, 0);
    jogar(7, 1, 1, 0);
    jogar(1, 4, 0, 0);
    jogar(3, 0, 1, 0);
    jogar(1, 8, 0, 0);
    verifica("fim_jogo", fim_jogo, 1);
    verifica("vencedor", vencedor, 2'b01);
    jogar(8, 8, 1, 0);
    compara_memoria("fim");

    // inicia while busy is ignored
    aplica_reset();
    jogar(4, 4, 0, 1);
    repeat (3) begin @(posedge clock); #1; end
    verifica("pulso_ignorado_idle", ocupado, 0);
    compara_memoria("pulso_ignorado");

    // Reset at +10 of a move
    macro_idx = 4'd1; micro_idx = 4'd1; jogador = 1'b0; inicia = 1'b1;
    @(posedge clock); #1;
    inicia = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    verifica("meio_ocupado", ocupado, 1);
    aplica_reset();
    compara_memoria("reset_meio");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falha);
    $finish;
  end

endmodule

// File: doc/atualiza_tabuleiro.md
ATUALIZA_TABULEIRO -- requirements
Module: atualiza_tabuleiro

Interface
REQ-001 SHALL have port: clock  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: inicia  in  1  one-cycle request to commit a move.
REQ-004 SHALL have port: macro_idx  in  4  macro cell 0-8.
REQ-005 SHALL have port: micro_idx  in  4  micro cell 0-8.
REQ-006 SHALL have port: jogador  in  1  mover; 0 maps to code 01, 1 maps to code 10.
REQ-007 SHALL have port: ocupado  out  1  high in every state except IDLE.
REQ-008 SHALL have port: pronto  out  1  one-cycle done pulse.
REQ-009 SHALL have port: erro  out  1  high together with pronto when the move is rejected.
REQ-010 SHALL have port: micro_vencida  out  1  registered; this move closed its micro board (won or drawn).
REQ-011 SHALL have port: fim_jogo  out  1  sticky game-over flag.
REQ-012 SHALL have port: vencedor  out  2  00 none, 01 X, 10 O, 11 draw.
REQ-013 SHALL have port: macro_we  out  1  write strobe to the macro board-state RAM.
REQ-014 SHALL have port: macro_addr  out  4  RAM address.
REQ-015 SHALL have port: macro_data  out  2  RAM write data (00 in progress, 01 X, 10 O, 11 draw).

Function
REQ-016 SHALL hold 81 micro cells and a 9-entry macro shadow internally, 2 bits each, using the same encoding as macro_data; cell index = macro_idx*9 + micro_idx, which is 7 bits wide.
REQ-017 SHALL implement the Moore FSM LIMPA -> IDLE -> CHECA -> {ERRO | GRAVA} -> VARRE_MICRO -> ATUALIZA -> VARRE_MACRO -> FEITO -> IDLE, with ERRO -> IDLE.
REQ-018 SHALL, in LIMPA, drive macro_we=1, macro_data=00 and macro_addr equal to a counter stepping 0..8 over 9 cycles, then go to IDLE.
REQ-019 SHALL sample inicia only in IDLE, ignoring it in every other state, and SHALL latch macro_idx, micro_idx and jogador on the accepting cycle.
REQ-020 SHALL, in CHECA, reject the move (go to ERRO) if macro_idx>8, micro_idx>8, the target cell is nonzero, the macro shadow entry is nonzero, or fim_jogo=1.
REQ-021 SHALL, in ERRO, assert pronto=1 and erro=1 for one cycle and change no storage, so pronto appears 2 cycles after the accepting cycle.
REQ-022 SHALL, in GRAVA, write the player code into the target cell.
REQ-023 SHALL, in VARRE_MICRO, test one of the 8 lines per cycle (3 rows, 3 columns, 2 diagonals, line 0..7) for all three cells equal to the player code.
REQ-024 SHALL set the new macro value to the player code on a hit, else to 11 if all 9 micro cells are nonzero, else to 00.
REQ-025 SHALL, in ATUALIZA, when the new value is nonzero, write the macro shadow, pulse macro_we for one cycle with macro_addr = latched macro_idx, and set micro_vencida=1; otherwise SHALL not pulse macro_we and SHALL set micro_vencida=0.
REQ-026 SHALL, in VARRE_MACRO, scan the 8 lines of the macro shadow against the player code, where 11 never matches.
REQ-027 SHALL, on a hit, set fim_jogo=1 and vencedor=player code; else, if all 9 shadow entries are nonzero, set fim_jogo=1 and vencedor=11.
REQ-028 SHALL, in FEITO, assert pronto=1 and erro=0 for one cycle, so that pronto appears exactly 20 cycles after the accepting cycle, a fixed latency with no early exit.
REQ-029 SHALL hold fim_jogo and vencedor until reset.
REQ-030 SHALL hold micro_vencida until the next accepted inicia.

Reset
REQ-031 SHALL, on reset, clear all 81 cells, the shadow, fim_jogo, vencedor, micro_vencida, pronto and erro, and set state=LIMPA with counter=0, including reset mid-operation.
REQ-032 SHALL reach IDLE on the 9th cycle after reset deassertion; macro_we being high during reset is permitted (address 0, data 00).

Structure
REQ-033 SHALL take from shared package jogo_pkg: cell codes (VAZIO, X, O, EMPATE), FSM state enum, the 8x3 line-index constant table, and N_CELULAS=9.
REQ-034 SHALL use one combinational sub-module verifica_linha (inputs: 9x2 board, line index, code; output: hit), instantiated for both scans.

Verification
REQ-035 SHALL verify reset: release reset -> macro_we high with addr 0..8 and data 00 for 9 cycles, ocupado=1, then IDLE with ocupado=0.
REQ-036 SHALL verify a simple move: macro 4, micro 0, jogador 0 -> pronto at +20, erro=0, micro_vencida=0, no macro_we pulse.
REQ-037 SHALL verify a micro win: X takes macro 2 micro 0,4,8 (O moves elsewhere) -> third X move pulses macro_we addr 2 data 01, micro_vencida=1.
REQ-038 SHALL verify rejections: repeat an occupied cell, micro_idx=9, or a move into a won macro -> pronto+erro at +2, and a subsequent dump shows storage unchanged.
REQ-039 SHALL verify game end: X wins macro 0,1,2 -> fim_jogo=1, vencedor=01; a further inicia -> erro.
REQ-040 SHALL verify timing boundaries: inicia pulsed while ocupado is ignored; reset asserted at cycle +10 of a move -> all cleared, LIMPA sequence restarts.
